// File: rtl/reg_jogador_seletor.sv
// Player-selection register: debounces one-hot player buttons and registers the chosen index.
// It rejects multi-press patterns and dead players, and needs a release before the next selection.
module reg_jogador_seletor #(
    parameter int N_JOGADORES    = 5,
    parameter int ID_W           = 3,
    parameter int ESTAVEL_CICLOS = 4,
    parameter int CNT_W          = 3
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [N_JOGADORES-1:0] botoes_jogadores,
    input  logic [N_JOGADORES-1:0] jogadores_vivos,
    input  logic                   habilita,
    input  logic                   limpa,
    output logic [ID_W-1:0]        jogador_escolhido,
    output logic                   escolha_valida,
    output logic                   escolha_pronta,
    output logic                   erro_multiplo,
    output logic                   erro_morto
);

    typedef enum logic [1:0] {
        OCIOSO,
        ESTABILIZA,
        AGUARDA_SOLTAR
    } estado_t;

    localparam logic [CNT_W-1:0] CNT_ALVO = CNT_W'(ESTAVEL_CICLOS);

    estado_t                estado, estado_nxt;
    logic [N_JOGADORES-1:0] amostra, amostra_nxt;
    logic [CNT_W-1:0]       contador, contador_nxt;
    logic [CNT_W-1:0]       contador_inc;
    logic [ID_W-1:0]        escolhido_nxt;
    logic                   valida_nxt, pronta_nxt, multiplo_nxt, morto_nxt;

    logic                   avalia;
    logic                   visto, multiplo;
    logic [ID_W-1:0]        indice;

    // Decode of the live button pattern. On an evaluation edge this pattern equals amostra.
    always_comb begin
        visto    = 1'b0;
        multiplo = 1'b0;
        indice   = '0;
        for (int i = 0; i < N_JOGADORES; i++) begin
            if (botoes_jogadores[i]) begin
                if (visto) multiplo = 1'b1;
                visto  = 1'b1;
                indice = ID_W'(i);
            end
        end
    end

    assign contador_inc = contador + CNT_W'(1);

    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        estado_nxt    = estado;
        amostra_nxt   = amostra;
        contador_nxt  = contador;
        escolhido_nxt = jogador_escolhido;
        valida_nxt    = escolha_valida;
        pronta_nxt    = 1'b0;
        multiplo_nxt  = 1'b0;
        morto_nxt     = 1'b0;
        avalia        = 1'b0;

        unique case (estado)
            OCIOSO: begin
                if (habilita && (botoes_jogadores != '0)) begin
                    amostra_nxt  = botoes_jogadores;
                    contador_nxt = CNT_W'(1);
                    if (ESTAVEL_CICLOS == 1) avalia = 1'b1;
                    else                     estado_nxt = ESTABILIZA;
                end
            end
            ESTABILIZA: begin
                if (!habilita || (botoes_jogadores == '0)) begin
                    estado_nxt = OCIOSO;
                end else if (botoes_jogadores != amostra) begin
                    amostra_nxt  = botoes_jogadores;
                    contador_nxt = CNT_W'(1);
                end else begin
                    contador_nxt = contador_inc;
                    if (contador_inc == CNT_ALVO) avalia = 1'b1;
                end
            end
            AGUARDA_SOLTAR: begin
                if (botoes_jogadores == '0) estado_nxt = OCIOSO;
            end
            default: estado_nxt = OCIOSO;
        endcase

        if (avalia) begin
            estado_nxt = AGUARDA_SOLTAR;
            if (multiplo) begin
                multiplo_nxt = 1'b1;
            end else if ((botoes_jogadores & jogadores_vivos) == '0) begin
                morto_nxt = 1'b1;
            end else begin
                escolhido_nxt = indice;
                valida_nxt    = 1'b1;
                pronta_nxt    = 1'b1;
            end
        end

        // A clear drops any in-progress debounce, and it suppresses the pulses of this edge.
        if (limpa) begin
            estado_nxt    = OCIOSO;
            escolhido_nxt = '0;
            valida_nxt    = 1'b0;
            pronta_nxt    = 1'b0;
            multiplo_nxt  = 1'b0;
            morto_nxt     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            estado            <= OCIOSO;
            amostra           <= '0;
            contador          <= '0;
            jogador_escolhido <= '0;
            escolha_valida    <= 1'b0;
            escolha_pronta    <= 1'b0;
            erro_multiplo     <= 1'b0;
            erro_morto        <= 1'b0;
        end else begin
            estado            <= estado_nxt;
            amostra           <= amostra_nxt;
            contador          <= contador_nxt;
            jogador_escolhido <= escolhido_nxt;
            escolha_valida    <= valida_nxt;
            escolha_pronta    <= pronta_nxt;
            erro_multiplo     <= multiplo_nxt;
            erro_morto        <= morto_nxt;
        end
    end

endmodule
